// File: rtl/clock_en_ctrl_if.sv
// clock_en_ctrl_if
//   Host/debug-side bundle for the processor clock-enable controller.
//   Optional signal: cycle_cnt exists only when CLKCTL_CYCLE_CNT_EN is defined.
// Signals
//   run        host -> ctrl  level, free-run request
//   step       host -> ctrl  one-cycle pulse, single enable period from halt
//   div_req    host -> ctrl  divisor change request (rising edge captures div_val)
//   div_val    host -> ctrl  requested divisor (N-1)
//   div_ack    ctrl -> host  one-cycle pulse, new divisor in effect
//   div_cur    ctrl -> host  divisor currently in effect
//   ce_out     ctrl -> core  one-cycle clock-enable strobe
//   div_clk    ctrl -> core  toggles on every strobe (period 2N)
//   halted     ctrl -> host  high while halted
//   cycle_cnt  ctrl -> host  strobes issued (CLKCTL_CYCLE_CNT_EN only)
interface clock_en_ctrl_if #(
    parameter int DIV_W = 4
`ifdef CLKCTL_CYCLE_CNT_EN
    , parameter int CNT_W = 32
`endif
);
    logic             run;
    logic             step;
    logic             div_req;
    logic [DIV_W-1:0] div_val;
    logic             div_ack;
    logic [DIV_W-1:0] div_cur;
    logic             ce_out;
    logic             div_clk;
    logic             halted;
`ifdef CLKCTL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output run, step, div_req, div_val,
        input  div_ack, div_cur, ce_out, div_clk, halted, cycle_cnt
    );
    modport slave (
        input  run, step, div_req, div_val,
        output div_ack, div_cur, ce_out, div_clk, halted, cycle_cnt
    );
`else
    modport master (
        output run, step, div_req, div_val,
        input  div_ack, div_cur, ce_out, div_clk, halted
    );
    modport slave (
        input  run, step, div_req, div_val,
        output div_ack, div_cur, ce_out, div_clk, halted
    );
`endif
endinterface

// File: rtl/clock_en_ctrl.sv
// clock_en_ctrl
//   Run/halt/step controller and programmable rate scheduler for the processor
//   clock. Issues a one-cycle enable strobe every N = div_cur+1 input cycles and
//   a toggle clock (div_clk) that flips on every strobe.
//   Optional feature macro: CLKCTL_CYCLE_CNT_EN adds the CNT_W parameter and the
//   cycle_cnt strobe counter.
// Ports
//   in_clk  input clock
//   rst     asynchronous active-high reset
//   bus     clock_en_ctrl_if.slave: run/step/divisor handshake and outputs
module clock_en_ctrl #(
    parameter int DIV_W   = 4,
    parameter int DIV_RST = 0
`ifdef CLKCTL_CYCLE_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic              in_clk,
    input  logic              rst,
    clock_en_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] pend_val;
    logic             pending;
    logic             req_d;
    logic             ce;
    logic             dclk;
    logic             ack;
    logic             halted_c;
    logic             terminal;
    logic             req_edge;
    logic             apply;

    // Last cycle of an enable period; the strobe itself appears one cycle later.
    assign terminal = ((state == S_RUN) || (state == S_STEP)) && (cnt == div_cur);
    assign req_edge = bus.div_req & ~req_d;
    // While halted there is no period in flight, so a pending divisor applies at once.
    assign apply    = pending & (terminal | (state == S_HALT));

    // FSM state register
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            state <= S_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a running period always completes before halting.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HALT: begin
                if (bus.run) begin
                    state_nxt = S_RUN;
                end else if (bus.step) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (terminal && !bus.run) begin
                    state_nxt = S_HALT;
                end
            end
            S_STEP: begin
                if (terminal) begin
                    state_nxt = bus.run ? S_RUN : S_HALT;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end

    // FSM outputs
    always_comb begin
        halted_c = 1'b0;
        if (state == S_HALT) begin
            halted_c = 1'b1;
        end
    end

    // Period counter, divisor handshake and strobe generation
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            req_d   <= 1'b0;
            pending <= 1'b0;
            div_cur <= DIV_W'(DIV_RST);
            ack     <= 1'b0;
            ce      <= 1'b0;
            dclk    <= 1'b0;
        end else begin
            if ((state == S_HALT) || terminal) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            req_d <= bus.div_req;
            // Capture and apply are mutually exclusive on pending, so an edge
            // arriving while a request is outstanding is simply dropped.
            if (apply) begin
                pending <= 1'b0;
                div_cur <= pend_val;
            end else if (req_edge && !pending) begin
                pending <= 1'b1;
            end
            ack <= apply;

            ce <= terminal;
            if (terminal) begin
                dclk <= ~dclk;
            end
        end
    end

    // Requested divisor holding register; only meaningful while pending is set.
    always_ff @(posedge in_clk) begin
        if (req_edge && !pending) begin
            pend_val <= bus.div_val;
        end
    end

`ifdef CLKCTL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_cnt;

    // Counted on the terminal cycle so the count moves together with ce_out.
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (terminal) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    assign bus.cycle_cnt = cycle_cnt;
`endif

    assign bus.div_ack = ack;
    assign bus.div_cur = div_cur;
    assign bus.ce_out  = ce;
    assign bus.div_clk = dclk;
    assign bus.halted  = halted_c;

endmodule
